// File: rtl/router_pkg.sv
// Shared types and constants for the router link transmitter.
package router_pkg;

  localparam int FLIT_W     = 8;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    BLOCKED = 2'd2
  } tx_state_t;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry FIFO between the crossbar handshake and the link output register.
module tx_skid_buf #(
  parameter int DATA_W = router_pkg::FLIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/router_link_tx.sv
// Credit-flow-controlled writer for the downstream router's input FIFO.
// Optional ROUTER_LINK_TX_STATS_EN adds a 16-bit wrapping flit_count output.
module router_link_tx #(
  parameter int FLIT_W = router_pkg::FLIT_W,
  parameter int DEPTH  = router_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_ready,
  input  logic              credit_in,
  output logic              link_write,
  output logic [FLIT_W-1:0] link_data,
  output logic              credit_err,
  output logic              busy
`ifdef ROUTER_LINK_TX_STATS_EN
  ,
  output logic [15:0]       flit_count
`endif
);

  import router_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic [CW-1:0]     credits;
  logic [CW-1:0]     credits_nxt;
  logic [1:0]        buf_count;
  logic [1:0]        count_nxt;
  logic [FLIT_W-1:0] head;
  logic              push;
  logic              send;
  logic              overflow;
  tx_state_t         state;

  // Saturating credit update: a simultaneous send and return cancel out.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic dec,
                                                input logic inc);
    if (dec && !inc)
      return cur - CW'(1);
    else if (inc && !dec && cur != CRED_MAX)
      return cur + CW'(1);
    else
      return cur;
  endfunction

  function automatic tx_state_t state_next(input logic [1:0] cnt,
                                           input logic [CW-1:0] cr);
    if (cnt == 2'd0)
      return IDLE;
    else if (cr == '0)
      return BLOCKED;
    else
      return SEND;
  endfunction

  assign in_ready = (buf_count != 2'd2);
  assign push     = in_valid && in_ready;
  assign send     = (buf_count != 2'd0) && (credits != '0);
  assign overflow = credit_in && !send && (credits == CRED_MAX);

  always_comb begin
    count_nxt = buf_count;
    case ({push, send})
      2'b10:   count_nxt = buf_count + 2'd1;
      2'b01:   count_nxt = buf_count - 2'd1;
      default: count_nxt = buf_count;
    endcase
    credits_nxt = credit_next(credits, send, credit_in);
  end

  tx_skid_buf #(.DATA_W(FLIT_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (send),
    .head      (head),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
      link_write <= 1'b0;
      link_data  <= '0;
      state      <= IDLE;
    end else begin
      link_write <= send;
      if (send)     link_data  <= head;
      if (overflow) credit_err <= 1'b1;
      credits <= credits_nxt;
      state   <= state_next(count_nxt, credits_nxt);
    end
  end

  // State is non-IDLE exactly when the buffer holds flits.
  assign busy = (state != IDLE) || (credits != CRED_MAX);

`ifdef ROUTER_LINK_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flit_count <= 16'd0;
    else if (send)
      flit_count <= flit_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_router_link_tx.sv
// Randomized and directed bench for router_link_tx against a queue-based model.
module tb_router_link_tx;

  import router_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  flit_t in_data;
  logic  in_ready;
  logic  credit_in;
  logic  link_write;
  flit_t link_data;
  logic  credit_err;
  logic  busy;
`ifdef ROUTER_LINK_TX_STATS_EN
  logic [15:0] flit_count;
`endif

  router_link_tx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .credit_in  (credit_in),
    .link_write (link_write),
    .link_data  (link_data),
    .credit_err (credit_err),
    .busy       (busy)
`ifdef ROUTER_LINK_TX_STATS_EN
    ,
    .flit_count (flit_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: buffered flits, credit balance, downstream occupancy.
  flit_t mq[$];
  int    m_cred;
  bit    m_err;
  bit    m_lw;
  flit_t m_ld;
  int    ds_occ;
  int    m_writes;

  function automatic tx_state_t m_state();
    if (mq.size() == 0)  return IDLE;
    else if (m_cred == 0) return BLOCKED;
    else                  return SEND;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cred   = DEPTH;
    m_err    = 1'b0;
    m_lw     = 1'b0;
    m_ld     = '0;
    ds_occ   = 0;
    m_writes = 0;
  endtask

  task automatic model_step(input logic v, input flit_t d, input logic c, output bit acc);
    bit snd;
    acc = v && (mq.size() < 2);
    snd = (mq.size() > 0) && (m_cred > 0);
    m_lw = snd;
    if (snd) begin
      m_ld = mq.pop_front();
      m_writes++;
    end
    if (acc) mq.push_back(d);
    if (snd && !c)
      m_cred--;
    else if (c && !snd) begin
      if (m_cred == DEPTH) m_err = 1'b1;
      else                 m_cred++;
    end
    if (snd) ds_occ++;
    if (c && ds_occ > 0) ds_occ--;
  endtask

  task automatic compare_all();
    check("link_write", 32'(link_write), 32'(m_lw));
    check("link_data",  32'(link_data),  32'(m_ld));
    check("in_ready",   32'(in_ready),   32'(mq.size() < 2));
    check("busy",       32'(busy),       32'((mq.size() > 0) || (m_cred < DEPTH)));
    check("credit_err", 32'(credit_err), 32'(m_err));
    check("credits",    32'(dut.credits), 32'(m_cred));
    check("state",      32'(dut.state),  32'(m_state()));
    check("ds_bound",   32'(ds_occ <= DEPTH), 32'd1);
`ifdef ROUTER_LINK_TX_STATS_EN
    check("flit_count", 32'(flit_count), 32'(m_writes & 16'hFFFF));
`endif
  endtask

  task automatic tick(input logic v, input flit_t d, input logic c, output bit acc);
    in_valid  = v;
    in_data   = d;
    credit_in = c;
    @(posedge clk);
    model_step(v, d, c, acc);
    #1;
    compare_all();
    in_valid  = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    credit_in = 1'b0;
    #1;
    check("rst_link_write", 32'(link_write), 32'd0);
    check("rst_link_data",  32'(link_data),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);
`ifdef ROUTER_LINK_TX_STATS_EN
    check("rst_flit_count", 32'(flit_count), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Offer flits 0..9 as fast as accepted, never returning credits.
  task automatic stream10(output int nwr);
    bit acc;
    int idx;
    idx = 0;
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      tick(idx < 10, flit_t'(idx), 1'b0, acc);
      if (acc) idx++;
      if (link_write) nwr++;
    end
    check("stream_accepted", 32'(idx), 32'd10);
  endtask

  initial begin
    bit acc;
    int nwr;
    in_data = '0;

    // Single flit latency
    do_reset();
    tick(1'b1, 8'hA1, 1'b0, acc);
    check("lat_edge1_no_write", 32'(link_write), 32'd0);
    check("lat_ready", 32'(in_ready), 32'd1);
    tick(1'b0, 8'h00, 1'b0, acc);
    check("lat_write", 32'(link_write), 32'd1);
    check("lat_data", 32'(link_data), 32'hA1);
    check("lat_credits", 32'(dut.credits), 32'd7);
    tick(1'b0, 8'h00, 1'b0, acc);
    check("lat_one_pulse", 32'(link_write), 32'd0);

    // Credit exhaustion and resume
    do_reset();
    stream10(nwr);
    check("stream_writes", 32'(nwr), 32'd8);
    check("stream_last_data", 32'(link_data), 32'h07);
    check("blocked_state", 32'(dut.state), 32'(BLOCKED));
    check("blocked_ready", 32'(in_ready), 32'd0);
    tick(1'b0, 8'h00, 1'b1, acc);
    check("resume_no_write_yet", 32'(link_write), 32'd0);
    tick(1'b0, 8'h00, 1'b0, acc);
    check("resume_write", 32'(link_write), 32'd1);
    check("resume_data", 32'(link_data), 32'h08);
    check("resume_ready", 32'(in_ready), 32'd1);

    // Steady state with immediate credit returns
    do_reset();
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, flit_t'($urandom), ds_occ > 0, acc);
      if (link_write) nwr++;
    end
    check("steady_writes", 32'(nwr), 32'd19);
    check("steady_credits", 32'(dut.credits), 32'd7);

    // Credit overflow is sticky and saturates
    do_reset();
    tick(1'b0, 8'h00, 1'b1, acc);
    check("ovf_err", 32'(credit_err), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0, acc);
    check("ovf_err_sticky", 32'(credit_err), 32'd1);
    check("ovf_credits", 32'(dut.credits), 32'(DEPTH));
    check("ovf_no_write", 32'(link_write), 32'd0);

    // Reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, flit_t'(8'h40 + i), 1'b0, acc);
    check("mid_credits", 32'(dut.credits), 32'd3);
    check("mid_busy", 32'(busy), 32'd1);
    do_reset();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    stream10(nwr);
    check("post_rst_writes", 32'(nwr), 32'd8);

    // Randomized traffic with a well-behaved downstream
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 3) != 0, flit_t'($urandom),
           (ds_occ > 0) && ($urandom_range(0, 2) == 0), acc);
    end

    // Randomized traffic including spurious credits
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(0, 1) != 0, flit_t'($urandom),
           $urandom_range(0, 3) == 0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
